// File: rtl/vga_pkg.sv
// Shared VGA definitions: one-hot output-stage states, pixel width and the
// default FIFO sizing used by the pixel output block.
package vga_pkg;

    localparam int AW_DEF     = 4;
    localparam int MARGIN_DEF = 2;
    localparam int PIX_W      = 24;

    typedef enum logic [3:0] {
        ST_DIS  = 4'b0001,
        ST_SYNC = 4'b0010,
        ST_ACT  = 4'b0100,
        ST_URUN = 4'b1000
    } state_e;

endpackage

// File: rtl/vga_rgb_fifo.sv
// Show-ahead synchronous FIFO for packed RGB pixels with a flush input and
// both the current and the next-cycle fill level exposed.
module vga_rgb_fifo #(
    parameter int AW = 4,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level,
    output logic [AW:0]   level_next,
    output logic          empty,
    output logic          full
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          wr_ok, rd_ok;

    assign empty      = (level_q == '0);
    assign full       = (level_q == (AW+1)'(DEPTH));
    assign level      = level_q;
    assign level_next = level_d;
    assign rd_data    = mem[rd_ptr_q];

    // A write into a full FIFO is dropped even when a pop happens alongside it.
    always_comb begin
        wr_ok    = wr_en & ~full & ~flush;
        rd_ok    = rd_en & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/vga_pixel_out.sv
// VGA pixel output stage: buffers RGB from the colour processor and emits it
// in step with the timing generator, with underrun recovery at frame start.
module vga_pixel_out
    import vga_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int MARGIN = MARGIN_DEF
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       ven,
    input  logic       wreq,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    output logic       fifo_full,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       blank_i,
    input  logic       clr_flags,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       blank_o,
    output logic       underrun,
    output logic       overflow,
    output logic       resync
);

    localparam int DEPTH = 1 << AW;

    state_e           state_q, state_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, vsync_q, blank_q;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    logic             resync_q, resync_d;
    logic             fifo_full_q, fifo_full_d;

    logic             pop, flush, vs_rise, underrun_set, overflow_set;
    logic [PIX_W-1:0] fifo_rd_data;
    logic [AW:0]      fifo_level, fifo_level_next, free_next;
    logic             fifo_empty, fifo_at_max;

    vga_rgb_fifo #(.AW(AW), .DW(PIX_W)) u_fifo (
        .clk        (clk),
        .srst       (srst),
        .flush      (flush),
        .wr_en      (wreq),
        .wr_data    ({R, G, B}),
        .rd_en      (pop),
        .rd_data    (fifo_rd_data),
        .level      (fifo_level),
        .level_next (fifo_level_next),
        .empty      (fifo_empty),
        .full       (fifo_at_max)
    );

    // vsync_q doubles as the previous-cycle vsync_i for edge detection.
    assign vs_rise = vsync_i & ~vsync_q;

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        flush        = 1'b0;
        underrun_set = 1'b0;
        resync_d     = 1'b0;
        if (!ven) begin
            state_d = ST_DIS;
            flush   = 1'b1;
        end else begin
            case (state_q)
                ST_DIS: begin
                    flush   = 1'b1;
                    state_d = ST_SYNC;
                end
                ST_SYNC: if (vs_rise) state_d = ST_ACT;
                ST_ACT: begin
                    if (!blank_i) begin
                        if (fifo_empty) begin
                            underrun_set = 1'b1;
                            state_d      = ST_URUN;
                        end else begin
                            pop = 1'b1;
                        end
                    end
                end
                ST_URUN: begin
                    if (vs_rise) begin
                        flush    = 1'b1;
                        resync_d = 1'b1;
                        state_d  = ST_ACT;
                    end
                end
                default: begin
                    state_d = ST_DIS;
                    flush   = 1'b1;
                end
            endcase
        end
    end

    // Almost-full looks at next-cycle level so a write already in flight upstream still fits.
    assign free_next = (AW+1)'(DEPTH) - fifo_level_next;

    always_comb begin
        overflow_set = wreq & fifo_at_max & ~flush;
        rgb_d        = pop ? fifo_rd_data : '0;
        underrun_d   = underrun_set | (underrun_q & ~clr_flags);
        overflow_d   = overflow_set | (overflow_q & ~clr_flags);
        fifo_full_d  = (int'(free_next) <= MARGIN);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_DIS;
            rgb_q       <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            blank_q     <= 1'b1;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            resync_q    <= 1'b0;
            fifo_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_i;
            vsync_q     <= vsync_i;
            blank_q     <= blank_i;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            resync_q    <= resync_d;
            fifo_full_q <= fifo_full_d;
        end
    end

    assign r_o       = rgb_q[23:16];
    assign g_o       = rgb_q[15:8];
    assign b_o       = rgb_q[7:0];
    assign hsync_o   = hsync_q;
    assign vsync_o   = vsync_q;
    assign blank_o   = blank_q;
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;
    assign resync    = resync_q;
    assign fifo_full = fifo_full_q;

endmodule
